// File: rtl/alu_control_md_if.sv
// ---------------------------------------------------------------------------
// alu_control_md_if
//   Bundles the signals between the main control/datapath and the ALU
//   control + multiply/divide unit.
//
//   master : issuing side (main control / testbench)
//   slave  : alu_control_md
//
//   valid        issue strobe for ALUOp/funct/operands this cycle
//   ALUOp[1:0]   from main control
//   funct[5:0]   instruction bits [5:0]
//   src_a/src_b  rs / rt operands
//   out_to_ALU   4-bit ALU control code
//   illegal      ALUOp=10 with an undecoded funct
//   stall        hold PC and pipeline this cycle
//   md_done      one-cycle pulse when HI/LO are written by mult/div
//   div_zero     one-cycle pulse with md_done when the divisor was 0
//   hilo_rd      mfhi/mflo read data
//   hi, lo       architectural HI/LO
// ---------------------------------------------------------------------------
interface alu_control_md_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [3:0]       out_to_ALU;
    logic             illegal;
    logic             stall;
    logic             md_done;
    logic             div_zero;
    logic [WIDTH-1:0] hilo_rd;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid, ALUOp, funct, src_a, src_b,
        input  out_to_ALU, illegal, stall, md_done, div_zero, hilo_rd, hi, lo
    );

    modport slave (
        input  valid, ALUOp, funct, src_a, src_b,
        output out_to_ALU, illegal, stall, md_done, div_zero, hilo_rd, hi, lo
    );
endinterface

// File: rtl/alu_control_md.sv
// ---------------------------------------------------------------------------
// alu_control_md
//   ALU control decoder for a MIPS-style datapath plus an iterative
//   multiply/divide sequencer owning the HI/LO registers.
//
//   Decoder : ALUOp/funct -> 4-bit ALU control code, illegal-funct flag.
//   Sequencer: mult/multu (shift-add) and div/divu (restoring), one step
//              per cycle, WIDTH steps, then a sign-fix cycle that writes
//              HI/LO and pulses md_done.  mfhi/mflo/mthi/mtlo access HI/LO
//              directly when the sequencer is idle; any HI/LO instruction
//              issued while it is busy raises stall.
//
// Ports
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    alu_control_md_if.slave (see interface file for signal list)
//
// Build option
//   ALU_CTL_REG_EN  when defined, out_to_ALU and illegal are registered
//                   (one cycle after ALUOp/funct); otherwise they are
//                   combinational.  The sequencer is identical either way.
//
// FSM
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation in flight; HI/LO moves and reads serviced
//   RUN    | one multiply or divide step per cycle, count 0..WIDTH-1
//   FIX    | sign correction, HI/LO write, md_done (and div_zero) pulse
// ---------------------------------------------------------------------------
module alu_control_md #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    alu_control_md_if.slave bus
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    logic w_rtype;
    logic w_md_grp;
    logic w_muldiv;
    logic w_is_div;
    logic w_signed;
    logic w_mthi;
    logic w_mtlo;

    assign w_rtype  = (bus.ALUOp == 2'b10);
    assign w_muldiv = w_rtype && (bus.funct == FN_MULT || bus.funct == FN_MULTU ||
                                  bus.funct == FN_DIV  || bus.funct == FN_DIVU);
    assign w_md_grp = w_muldiv ||
                      (w_rtype && (bus.funct == FN_MFHI || bus.funct == FN_MTHI ||
                                   bus.funct == FN_MFLO || bus.funct == FN_MTLO));
    // div/divu are 01101x; signed variants have funct[0]=0
    assign w_is_div = bus.funct[1];
    assign w_signed = ~bus.funct[0];
    assign w_mthi   = w_rtype && (bus.funct == FN_MTHI);
    assign w_mtlo   = w_rtype && (bus.funct == FN_MTLO);

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    logic [3:0] w_ctl;
    logic       w_illegal;

    always_comb begin
        w_ctl     = CTL_ADD;
        w_illegal = 1'b0;
        case (bus.ALUOp)
            2'b00: w_ctl = CTL_ADD;
            2'b01: w_ctl = CTL_SUB;
            2'b11: w_ctl = CTL_OR;
            default: begin
                case (bus.funct)
                    6'b100000, 6'b100001: w_ctl = CTL_ADD;
                    6'b100010, 6'b100011: w_ctl = CTL_SUB;
                    6'b100100:            w_ctl = CTL_AND;
                    6'b100101:            w_ctl = CTL_OR;
                    6'b100111:            w_ctl = CTL_NOR;
                    6'b101010, 6'b101011: w_ctl = CTL_SLT;
                    default: begin
                        // HI/LO group is legal; the ALU code is a don't-care
                        w_ctl     = CTL_ADD;
                        w_illegal = ~w_md_grp;
                    end
                endcase
            end
        endcase
    end

`ifdef ALU_CTL_REG_EN
    logic [3:0] r_ctl;
    logic       r_illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl     <= CTL_ADD;
            r_illegal <= 1'b0;
        end else begin
            r_ctl     <= w_ctl;
            r_illegal <= w_illegal;
        end
    end

    assign bus.out_to_ALU = r_ctl;
    assign bus.illegal    = r_illegal;
`else
    // reset forces the reset-state values even on the combinational path
    assign bus.out_to_ALU = reset ? CTL_ADD : w_ctl;
    assign bus.illegal    = reset ? 1'b0    : w_illegal;
`endif

    // ------------------------------------------------------------------
    // Sequencer datapath registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_acc;     // partial product high half / remainder
    logic [WIDTH-1:0] r_q;       // multiplier (shifting out) / quotient
    logic [WIDTH-1:0] r_m;       // multiplicand / divisor magnitude
    logic             r_is_div;
    logic             r_neg_lo;  // negate product (mul) or quotient (div)
    logic             r_neg_hi;  // negate remainder (div only)
    logic             r_dz;

    logic w_start;
    logic w_start_dz;

    assign w_start    = bus.valid && w_muldiv && (r_state == S_IDLE);
    assign w_start_dz = w_start && w_is_div && (bus.src_b == '0);

    // Operand magnitudes; -2^(W-1) maps to itself, which is the correct
    // unsigned magnitude
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_sgn_a;
    logic             w_sgn_b;

    assign w_sgn_a = w_signed && bus.src_a[WIDTH-1];
    assign w_sgn_b = w_signed && bus.src_b[WIDTH-1];
    assign w_mag_a = w_sgn_a ? -bus.src_a : bus.src_a;
    assign w_mag_b = w_sgn_b ? -bus.src_b : bus.src_b;

    // Multiply step: add multiplicand when the multiplier LSB is set,
    // then shift {acc,q} right by one
    logic [WIDTH:0] w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH-1:0] w_div_diff;
    logic             w_div_ge;

    assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_m});
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_m;

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;

    always_comb begin
        if (r_is_div) begin
            w_fix_lo = r_neg_lo ? -r_q   : r_q;
            w_fix_hi = r_neg_hi ? -r_acc : r_acc;
        end else begin
            w_fix_lo = w_prod_fix[WIDTH-1:0];
            w_fix_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = w_start_dz ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == LAST_STEP) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_md_done;
    logic w_div_zero;

    always_comb begin
        w_stall    = 1'b0;
        w_md_done  = 1'b0;
        w_div_zero = 1'b0;
        if (!reset) begin
            w_stall = bus.valid && w_md_grp && (r_state != S_IDLE);
            if (r_state == S_FIX) begin
                w_md_done  = 1'b1;
                w_div_zero = r_dz;
            end
        end
    end

    assign bus.stall    = w_stall;
    assign bus.md_done  = w_md_done;
    assign bus.div_zero = w_div_zero;

    // ------------------------------------------------------------------
    // Sequencer datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_count  <= '0;
                        r_is_div <= w_is_div;
                        r_dz     <= w_start_dz;
                        if (w_start_dz) begin
                            // FIX writes these through unchanged
                            r_acc    <= bus.src_a;
                            r_q      <= '1;
                            r_neg_lo <= 1'b0;
                            r_neg_hi <= 1'b0;
                        end else begin
                            r_acc    <= '0;
                            r_q      <= w_mag_a;
                            r_m      <= w_mag_b;
                            r_neg_lo <= w_sgn_a ^ w_sgn_b;
                            r_neg_hi <= w_is_div && w_sgn_a;
                        end
                    end else if (bus.valid && w_mthi) begin
                        r_hi <= bus.src_a;
                    end else if (bus.valid && w_mtlo) begin
                        r_lo <= bus.src_a;
                    end
                end
                S_RUN: begin
                    r_count <= r_count + CNT_W'(1);
                    if (r_is_div) begin
                        r_acc <= w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[WIDTH:1];
                        r_q   <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_count <= '0;
                end
                default: r_count <= '0;
            endcase
        end
    end

    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.hilo_rd = (bus.funct == FN_MFHI) ? r_hi : r_lo;

endmodule

// File: tb/tb_alu_control_md.sv
module tb_alu_control_md;
    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    alu_control_md_if #(.WIDTH(W)) bus ();

    alu_control_md #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [3:0] ctl;
        logic       ill;
    } dec_t;

    typedef struct {
        string         name;
        logic [W-1:0]  val;
    } rd_t;

    typedef struct {
        string        name;
        int           acc;
        int           lat;
        logic         dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } md_t;

    typedef struct {
        string        name;
        int           cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [3:0]   ctl;
        logic         ill;
        logic         stall;
        logic         mdd;
    } probe_t;

    dec_t   decq[$];
    rd_t    rdq[$];
    md_t    mdq[$];
    probe_t probeq[$];
    int     stallq[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic is_md(input logic [1:0] op, input logic [5:0] fn);
        return (op == 2'b10) && ((fn[5:2] == 4'b0100) || (fn[5:2] == 4'b0110));
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        md_t    mp;
        probe_t pr;
        dec_t   de;
        rd_t    re;
        bit     pend;
        int     scnt;
        int     sexp;
        pend = 0;
        scnt = 0;
        forever begin
            @(negedge clk);
            while (probeq.size() > 0 && probeq[0].cyc <= cyc) begin
                pr = probeq.pop_front();
                chk({pr.name, "_cycle"}, 64'(cyc), 64'(pr.cyc));
                chk({pr.name, "_hi"}, bus.hi, pr.hi);
                chk({pr.name, "_lo"}, bus.lo, pr.lo);
                chk({pr.name, "_ctl"}, bus.out_to_ALU, pr.ctl);
                chk({pr.name, "_illegal"}, bus.illegal, pr.ill);
                chk({pr.name, "_stall"}, bus.stall, pr.stall);
                chk({pr.name, "_md_done"}, bus.md_done, pr.mdd);
            end
            if (reset) begin
                pend = 0;
                scnt = 0;
                continue;
            end
            if (pend) begin
                chk({mp.name, "_hi"}, bus.hi, mp.hi);
                chk({mp.name, "_lo"}, bus.lo, mp.lo);
                pend = 0;
            end
            if (bus.md_done) begin
                if (mdq.size() == 0) begin
                    chk("unexpected_md_done", 64'(bus.md_done), 64'(0));
                end else begin
                    mp = mdq.pop_front();
                    chk({mp.name, "_latency"}, 64'(cyc - mp.acc), 64'(mp.lat));
                    chk({mp.name, "_div_zero"}, bus.div_zero, mp.dz);
                    pend = 1;
                end
            end else if (bus.div_zero) begin
                chk("div_zero_without_md_done", 64'(bus.div_zero), 64'(0));
            end
            if (bus.stall) begin
                scnt++;
            end else if (scnt > 0) begin
                sexp = (stallq.size() > 0) ? stallq.pop_front() : 0;
                chk("stall_length", 64'(scnt), 64'(sexp));
                scnt = 0;
            end
            if (bus.valid) begin
                if (!is_md(bus.ALUOp, bus.funct)) begin
                    if (decq.size() == 0) begin
                        chk("decode_queue_underflow", 64'(1), 64'(0));
                    end else begin
                        de = decq.pop_front();
                        chk({de.name, "_ctl"}, bus.out_to_ALU, de.ctl);
                        chk({de.name, "_illegal"}, bus.illegal, de.ill);
                        chk({de.name, "_stall"}, bus.stall, 1'b0);
                    end
                end else if (!bus.stall && (bus.funct == MFHI || bus.funct == MFLO)) begin
                    if (rdq.size() == 0) begin
                        chk("read_queue_underflow", 64'(1), 64'(0));
                    end else begin
                        re = rdq.pop_front();
                        chk(re.name, bus.hilo_rd, re.val);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
        logic s;
        int   n;
        n = 0;
        acc = -1;
        bus.valid = 1'b1;
        bus.ALUOp = op;
        bus.funct = fn;
        bus.src_a = a;
        bus.src_b = b;
        forever begin
            @(negedge clk);
            s = bus.stall;
            acc = cyc;
            @(posedge clk);
            #1;
            if (!s) break;
            n++;
            if (n > 200) begin
                chk("stall_timeout", 64'(s), 64'(0));
                break;
            end
        end
        bus.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic dec(input string name, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] ctl, input logic ill);
        int acc;
        decq.push_back('{name, ctl, ill});
        drive(op, fn, '0, '0, acc);
    endtask

    task automatic rd(input string name, input logic [5:0] fn, input logic [W-1:0] val,
                      input int stall_len);
        int acc;
        if (stall_len > 0) stallq.push_back(stall_len);
        rdq.push_back('{name, val});
        drive(2'b10, fn, '0, '0, acc);
    endtask

    task automatic md_op(input string name, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                         input logic dz, input logic [W-1:0] hi, input logic [W-1:0] lo);
        int acc;
        drive(2'b10, fn, a, b, acc);
        mdq.push_back('{name, acc, lat, dz, hi, lo});
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int acc;
        bus.valid = 1'b0;
        bus.ALUOp = 2'b10;
        bus.funct = 6'b000101;
        bus.src_a = '0;
        bus.src_b = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        probeq.push_back('{"reset_state", cyc, '0, '0, 4'b0010, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);

        // decode sweep
        dec("aluop00",      2'b00, 6'b011000, 4'b0010, 1'b0);
        dec("aluop01",      2'b01, 6'b100000, 4'b0110, 1'b0);
        dec("aluop11",      2'b11, 6'b000101, 4'b0001, 1'b0);
        dec("r_add",        2'b10, 6'b100000, 4'b0010, 1'b0);
        dec("r_addu",       2'b10, 6'b100001, 4'b0010, 1'b0);
        dec("r_subu",       2'b10, 6'b100011, 4'b0110, 1'b0);
        dec("r_and",        2'b10, 6'b100100, 4'b0000, 1'b0);
        dec("r_or",         2'b10, 6'b100101, 4'b0001, 1'b0);
        dec("r_nor",        2'b10, 6'b100111, 4'b1100, 1'b0);
        dec("r_slt",        2'b10, 6'b101010, 4'b0111, 1'b0);
        dec("r_sltu",       2'b10, 6'b101011, 4'b0111, 1'b0);
        dec("r_ill_000101", 2'b10, 6'b000101, 4'b0010, 1'b1);
        dec("r_ill_111111", 2'b10, 6'b111111, 4'b0010, 1'b1);
        idle(2);

        // HI/LO moves with same-cycle forwarding
        drive(2'b10, MTLO, 32'h0000_1234, '0, acc);
        rd("mflo_fwd", MFLO, 32'h0000_1234, 0);
        drive(2'b10, MTHI, 32'hCAFE_0001, '0, acc);
        rd("mfhi_fwd", MFHI, 32'hCAFE_0001, 0);
        idle(2);

        // multu max x max, mflo issued right behind it
        md_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b0,
              32'hFFFF_FFFE, 32'h0000_0001);
        rd("mflo_multu", MFLO, 32'h0000_0001, 33);
        rd("mfhi_multu", MFHI, 32'hFFFF_FFFE, 0);
        idle(2);

        // mult -3 x 7 with a non-md add slipping in during RUN
        md_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 33, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFEB);
        dec("add_during_run", 2'b10, 6'b100000, 4'b0010, 1'b0);
        rd("mflo_mult", MFLO, 32'hFFFF_FFEB, 32);
        rd("mfhi_mult", MFHI, 32'hFFFF_FFFF, 0);
        idle(2);

        // divides
        md_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 33, 1'b0,
              32'hFFFF_FFFF, 32'hFFFF_FFFD);
        idle(36);
        md_op("divu_zero", DIVU, 32'd7, 32'd0, 1, 1'b1, 32'd7, 32'hFFFF_FFFF);
        idle(3);
        md_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0,
              32'h0000_0000, 32'h8000_0000);
        rd("mflo_ovf", MFLO, 32'h8000_0000, 33);
        md_op("divu_100_7", DIVU, 32'd100, 32'd7, 33, 1'b0, 32'd2, 32'd14);
        idle(36);

        // reset in the middle of a divide: no md_done may follow
        drive(2'b10, DIV, 32'd1000, 32'd3, acc);
        while (cyc < acc + 10) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.ALUOp = 2'b00;
        probeq.push_back('{"post_reset", cyc, '0, '0, 4'b0010, 1'b0, 1'b0, 1'b0});
        idle(40);

        md_op("mult_after_reset", MULT, 32'd5, 32'd6, 33, 1'b0, 32'd0, 32'd30);
        rd("mflo_after_reset", MFLO, 32'd30, 33);
        idle(5);

        chk("decq_drained", 64'(decq.size()), 64'(0));
        chk("rdq_drained", 64'(rdq.size()), 64'(0));
        chk("mdq_drained", 64'(mdq.size()), 64'(0));
        chk("probeq_drained", 64'(probeq.size()), 64'(0));
        chk("stallq_drained", 64'(stallq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_control_md.md
Name: alu_control_md

Overview:
- Next-generation ALU control for the MIPS-style datapath, parametrised in data width.
- Decodes ALUOp/funct to the 4-bit ALU control code and adds NOR, an immediate mode (ALUOp=11) and an illegal-funct flag.
- Integrates an iterative multiply/divide sequencer with HI/LO registers, mfhi/mflo/mthi/mtlo, and a stall output to the main control.

Parameters:
- WIDTH, 32, operand and HI/LO width (>=4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- valid  input  1  instruction issue strobe for ALUOp/funct/operands this cycle.
- ALUOp  input  2  from main control.
- funct  input  6  instruction bits [5:0].
- src_a  input  WIDTH  rs operand.
- src_b  input  WIDTH  rt operand.
- out_to_ALU  output  4  ALU control code.
- illegal  output  1  ALUOp=10 with an undecoded funct.
- stall  output  1  hold PC and pipeline this cycle.
- md_done  output  1  one-cycle pulse when HI/LO are written by mult/div.
- div_zero  output  1  one-cycle pulse with md_done when the divisor was 0.
- hilo_rd  output  WIDTH  mfhi/mflo read data.
- hi, lo  output  WIDTH  architectural HI/LO.

Behaviour:
- Decode (combinational unless the optional feature is enabled):
  - ALUOp 00 -> 0010 (ADD); 01 -> 0110 (SUB); 11 -> 0001 (OR, ori/lui path).
  - ALUOp 10 with funct 100000/100001 -> 0010; 100010/100011 -> 0110; 100100 -> 0000; 100101 -> 0001; 100111 -> 1100; 101010/101011 -> 0111.
  - Any other funct under ALUOp 10, except the mult/div/HI/LO group, sets illegal=1 and out_to_ALU=0010.
- Mult/div group (ALUOp=10): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
- FSM states:
  - IDLE -> RUN on valid & mult/div funct: latch |src_a|, |src_b| (magnitudes if signed), result sign bits and op; count=0.
  - IDLE -> FIX on div/divu with src_b==0.
  - RUN: one shift-add (mul) or restoring-subtract (div) step per cycle; after WIDTH steps (count==WIDTH-1) -> FIX.
  - FIX: apply sign correction, write HI/LO, pulse md_done, -> IDLE.
- Latency: accept at cycle 0; md_done and HI/LO update at cycle WIDTH+1, visible at WIDTH+2.
- Results:
  - mult/multu: {HI,LO} = 2*WIDTH-bit product.
  - div/divu: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
  - Signed -2^(W-1)/-1: LO = 0x80..0, HI = 0 (wraps).
  - Divide by zero: LO = all ones, HI = src_a, div_zero=1 with md_done.
- Stall:
  - stall=1 when valid & (mult/div/mfhi/mflo/mthi/mtlo) & state!=IDLE.
  - stall deasserts in the cycle after FIX.
  - While stalled, the issuing instruction must be held and re-presented.
- mthi/mtlo in IDLE: HI/LO <= src_a at the next edge.
- mfhi/mflo in IDLE: hilo_rd = hi/lo combinationally.
- Same-cycle forwarding: mtlo followed immediately by mflo reads the written value, because the write has already taken effect.
- valid=0: no state change. Non-md instructions never stall and can issue while RUN is in progress.
- reset, including mid-operation: state IDLE, count 0, hi=lo=0, md_done=div_zero=stall=0, illegal=0, out_to_ALU=0010.

Optional Feature:
- Macro ALU_CTL_REG_EN.
- Defined: out_to_ALU and illegal are registered, valid one cycle after inputs; reset values are 0010 and 0.
- Undefined: both are combinational from ALUOp/funct with zero latency. The MD sequencer is unchanged either way.

Test Plan:
- Decode sweep, WIDTH=32:
  - ALUOp=00 -> 0010; 01 -> 0110; 11 -> 0001.
  - ALUOp=10 with funct 100100/100101/100111/101010 -> 0000/0001/1100/0111.
  - funct 000101 -> illegal=1, out_to_ALU=0010.
- multu 0xFFFFFFFF x 0xFFFFFFFF: md_done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001. mult -3 x 7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0: md_done at cycle 1 after accept, div_zero=1, LO=0xFFFFFFFF, HI=7.
- Stall: issue mult, then mflo on the next cycle -> stall=1 for cycles 1..33, then hilo_rd=LO; an intervening add issues without stall.
- mtlo 0x1234 then mflo -> hilo_rd=0x1234; signed div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- reset asserted at cycle 10 of a div -> next cycle hi=lo=0, stall=0, no md_done; a subsequent mult completes normally.
